// File: rtl/bf16_add_sequencer.sv
// Operand FIFO and single-operation sequencer in front of a bfloat16 adder FSM.
// Define BF16_SEQ_STATS_EN to add the saturating ops_done/timeouts counters.
module bf16_add_sequencer #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clock,
  input  logic        n_reset,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] adder_a,
  output logic [15:0] adder_b,
  input  logic        adder_ready,
  input  logic [15:0] adder_sum,
  output logic [15:0] out_sum,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
`ifdef BF16_SEQ_STATS_EN
  output logic [15:0] ops_done,
  output logic [15:0] timeouts,
`endif
  output logic        timeout
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, LOAD, BUSY} state_e;

  state_e        state_q;
  logic [AW:0]   wr_q, rd_q;
  logic [31:0]   mem_q [DEPTH];
  logic [WW-1:0] wd_q;
  logic [15:0]   adder_a_q, adder_b_q, out_sum_q;
  logic          out_valid_q, busy_q, timeout_q;
  logic          full, empty, push, pop, running, abort, capture;
  logic [31:0]   head;

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty = (wr_q == rd_q);
  assign push  = in_valid && !full;
  assign pop   = (state_q == IDLE) && !empty && !out_valid_q;
  assign head  = mem_q[rd_q[AW-1:0]];

  assign running = (state_q == LOAD) || (state_q == BUSY);
  assign abort   = running && !adder_ready && (wd_q == WW'(TIMEOUT_CYCLES - 1));
  assign capture = (state_q == BUSY) && adder_ready;

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_q[AW-1:0]] <= {in_a, in_b};
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= IDLE;
      wd_q        <= '0;
      adder_a_q   <= '0;
      adder_b_q   <= '0;
      out_sum_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      timeout_q <= abort;
      case (state_q)
        IDLE: if (pop) begin
          adder_a_q <= head[31:16];
          adder_b_q <= head[15:0];
          wd_q      <= '0;
          busy_q    <= 1'b1;
          state_q   <= LOAD;
        end
        // A ready pulse in LOAD ends any stale run; the adder starts ours next.
        LOAD: if (adder_ready) begin
          wd_q    <= '0;
          state_q <= BUSY;
        end else if (abort) begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end else begin
          wd_q <= wd_q + 1'b1;
        end
        BUSY: if (adder_ready) begin
          out_sum_q <= adder_sum;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end else if (abort) begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end else begin
          wd_q <= wd_q + 1'b1;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
      // Capture wins over a same-cycle drain.
      if (capture)                        out_valid_q <= 1'b1;
      else if (out_valid_q && out_ready)  out_valid_q <= 1'b0;
    end
  end

  assign in_ready  = !full;
  assign adder_a   = adder_a_q;
  assign adder_b   = adder_b_q;
  assign out_sum   = out_sum_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign timeout   = timeout_q;

`ifdef BF16_SEQ_STATS_EN
  logic [15:0] ops_q, tos_q;

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      ops_q <= '0;
      tos_q <= '0;
    end else begin
      if (capture && ops_q != 16'hFFFF) ops_q <= ops_q + 1'b1;
      if (abort && tos_q != 16'hFFFF)   tos_q <= tos_q + 1'b1;
    end
  end

  assign ops_done = ops_q;
  assign timeouts = tos_q;
`endif

endmodule

// File: tb/tb_bf16_add_sequencer.sv
// Randomized bench for bf16_add_sequencer: behavioural bf16 adder model plus
// an in-order expected-result queue built from accepted pushes.
module tb_bf16_add_sequencer;
  logic        clock = 1'b0;
  logic        n_reset;
  logic [15:0] in_a = '0, in_b = '0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, busy, timeout, adder_ready;
  logic [15:0] adder_a, adder_b, adder_sum, out_sum;
`ifdef BF16_SEQ_STATS_EN
  logic [15:0] ops_done, timeouts;
`endif

  bf16_add_sequencer #(.DEPTH(4), .TIMEOUT_CYCLES(64)) dut (
    .clock(clock), .n_reset(n_reset),
    .in_a(in_a), .in_b(in_b), .in_valid(in_valid), .in_ready(in_ready),
    .adder_a(adder_a), .adder_b(adder_b),
    .adder_ready(adder_ready), .adder_sum(adder_sum),
    .out_sum(out_sum), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy),
`ifdef BF16_SEQ_STATS_EN
    .ops_done(ops_done), .timeouts(timeouts),
`endif
    .timeout(timeout)
  );

  always #5 clock = ~clock;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Real-valued bf16 arithmetic (normals and zero), rounded to nearest-even.
  function automatic real bf16_to_real(input logic [15:0] h);
    logic [63:0] d;
    int e;
    if (h[14:7] == 8'd0) return 0.0;
    e = int'(h[14:7]) - 127 + 1023;
    d = {h[15], e[10:0], h[6:0], 45'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [15:0] real_to_bf16(input real r);
    logic [63:0] d;
    logic [14:0] v;
    int e;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return {d[63], 15'd0};
    e = int'(d[62:52]) - 1023 + 127;
    v = {e[7:0], d[51:45]};
    if (d[44] && ((|d[43:0]) || d[45])) v = v + 15'd1;
    return {d[63], v};
  endfunction

  function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
    return real_to_bf16(bf16_to_real(a) + bf16_to_real(b));
  endfunction

  function automatic logic [15:0] rnd_bf16();
    logic [15:0] v;
    v[15]   = 1'($urandom_range(0, 1));
    v[14:7] = 8'($urandom_range(120, 134));
    v[6:0]  = 7'($urandom_range(0, 127));
    return v;
  endfunction

  // Adder model: ready for one cycle, then samples a/b and runs a random length.
  int          cnt = 0, lmin = 0, lmax = 3;
  logic        stall = 1'b0;
  logic [15:0] sum_r = '0;
  assign adder_ready = !stall && (cnt == 0);
  assign adder_sum   = sum_r;
  always @(posedge clock) begin
    if (!stall) begin
      if (cnt == 0) begin
        sum_r <= ref_add(adder_a, adder_b);
        cnt   <= $urandom_range(lmin, lmax);
      end else begin
        cnt <= cnt - 1;
      end
    end
  end

  // Scoreboard: accepted pairs queue their sums; results must match in order.
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int          n_to = 0;
  always @(negedge clock) begin
    if (n_reset) begin
      if (out_valid && out_ready) begin
        chk("result_pending", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("result_order", out_sum, exp_q.pop_front());
        got_q.push_back(out_sum);
      end
      if (timeout) begin
        n_to++;
        chk("timeout_pending", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (in_valid && in_ready) exp_q.push_back(ref_add(in_a, in_b));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] b);
    int k = 0;
    @(posedge clock); #1;
    in_a = a; in_b = b; in_valid = 1'b1;
    @(negedge clock);
    while (!in_ready && k < 300) begin k++; @(negedge clock); end
    chk("push_accept", in_ready, 1);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || busy || out_valid) && k < budget) begin
      @(negedge clock); k++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    n_reset = 1'b0;
    #1 exp_q.delete();
    cyc(2);
    n_reset = 1'b1;
  endtask

  initial begin
    int acc, c, t0, t1, ov, k;
    logic qsent;
    n_reset = 1'b1;
    #3 n_reset = 1'b0;
    #10;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_adder_a", adder_a, 0);
    chk("rst_adder_b", adder_b, 0);
    chk("rst_out_sum", out_sum, 0);
    cyc(2);
    n_reset = 1'b1;

    // 1.0 + 2.0
    out_ready = 1'b1;
    got_q.delete();
    push(16'h3F80, 16'h4000);
    wait_drain(200);
    chk("t1_count", got_q.size(), 1);
    chk("t1_sum", got_q[0], 16'h4040);
    chk("t1_busy", busy, 0);

    // Back-pressure: 6 offered, 5 accepted
    @(posedge clock); #1 out_ready = 1'b0;
    got_q.delete();
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      in_valid = 1'b1; in_a = rnd_bf16(); in_b = rnd_bf16();
      @(negedge clock);
      if (in_ready) acc++;
    end
    @(posedge clock); #1 in_valid = 1'b0;
    chk("bp_accepted", acc, 5);
    cyc(20);
    chk("bp_in_ready_full", in_ready, 0);
    chk("bp_out_valid_held", out_valid, 1);
    @(posedge clock); #1 out_ready = 1'b1;
    wait_drain(500);
    chk("bp_results", got_q.size(), 5);
    chk("bp_in_ready_after", in_ready, 1);

    // Watchdog: stalled adder, second pair queued behind
    got_q.delete();
    k = n_to;
    stall = 1'b1;
    push(16'h3F80, 16'h3F80);
    in_a = 16'h4000; in_b = 16'h4040; in_valid = 1'b1;
    qsent = 1'b0; c = 0; t0 = -1; t1 = -1; ov = 0;
    while (t1 < 0 && c < 300) begin
      @(negedge clock); c++;
      if (busy && t0 < 0) t0 = c;
      if (out_valid) ov++;
      if (timeout) begin t1 = c; stall = 1'b0; end
      if (in_valid && in_ready) qsent = 1'b1;
      @(posedge clock); #1;
      if (qsent) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    chk("to_cycles", t1 - t0, 64);
    chk("to_no_out_valid", ov, 0);
    wait_drain(300);
    chk("to_pulses", n_to - k, 1);
    chk("to_next_result", got_q.size(), 1);

    // Reset while BUSY with 3 pairs queued
    lmin = 10; lmax = 10;
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      in_valid = 1'b1; in_a = rnd_bf16(); in_b = rnd_bf16();
    end
    @(posedge clock); #1 in_valid = 1'b0;
    stall = 1'b0;
    k = 0;
    @(negedge clock);
    while (!(busy && adder_ready) && k < 100) begin k++; @(negedge clock); end
    chk("rst_mid_load_exit", busy && adder_ready, 1);
    cyc(2);
    n_reset = 1'b0;
    #1;
    exp_q.delete();
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    chk("rst_mid_adder_a", adder_a, 0);
    chk("rst_mid_adder_b", adder_b, 0);
    lmin = 0; lmax = 3;
    cyc(2);
    n_reset = 1'b1;
    got_q.delete();
    cyc(150);
    chk("rst_no_results", got_q.size(), 0);
    chk("rst_idle", busy, 0);

    // Zero operand, then cancellation
    got_q.delete();
    push(16'h0000, 16'h4040);
    push(16'hC040, 16'h4040);
    wait_drain(300);
    chk("zero_count", got_q.size(), 2);
    chk("zero_sum0", got_q[0], 16'h4040);
    chk("zero_sum1", got_q[1], 16'h0000);

    // Random traffic with random back-pressure
    got_q.delete();
    acc = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clock); #1;
      in_valid  = 1'($urandom_range(0, 1));
      in_a      = rnd_bf16();
      in_b      = rnd_bf16();
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clock);
      if (in_valid && in_ready) acc++;
    end
    @(posedge clock); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    wait_drain(3000);
    chk("rand_count", got_q.size(), acc);

`ifdef BF16_SEQ_STATS_EN
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push(rnd_bf16(), rnd_bf16());
      wait_drain(300);
    end
    stall = 1'b1;
    push(16'h3F80, 16'h3F80);
    k = 0;
    @(negedge clock);
    while (!timeout && k < 200) begin k++; @(negedge clock); end
    stall = 1'b0;
    wait_drain(300);
    chk("stats_ops_done", ops_done, 3);
    chk("stats_timeouts", timeouts, 1);
    do_reset();
    #1;
    chk("stats_rst_ops", ops_done, 0);
    chk("stats_rst_to", timeouts, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bf16_add_sequencer.md
Name: bf16_add_sequencer

Overview:
Upstream operand front end for the bfloat16 adder FSM. It buffers operand pairs from a valid/ready producer in a FIFO and holds each pair stable on the adder's a/b inputs across one full adder run. It tracks the adder's ready pulses, captures the resulting sum into a single result register, and presents it downstream on a valid/ready interface. A watchdog aborts a run if the adder stops producing ready pulses.

Parameters:
DEPTH, 4, operand-pair FIFO entries; power of 2, minimum 2.
TIMEOUT_CYCLES, 64, maximum consecutive cycles in LOAD or BUSY without an adder_ready pulse.

Ports:
clock  input  1  system clock, rising edge
n_reset  input  1  asynchronous, active-low reset
in_a  input  16  operand A, bfloat16
in_b  input  16  operand B, bfloat16
in_valid  input  1  operand pair valid
in_ready  output  1  FIFO can accept a pair (= !full)
adder_a  output  16  to adder a; registered
adder_b  output  16  to adder b; registered
adder_ready  input  1  adder ready (high in its idle state)
adder_sum  input  16  adder sum; valid while adder_ready=1
out_sum  output  16  captured result
out_valid  output  1  result register full
out_ready  input  1  downstream accepts result
busy  output  1  state != IDLE
timeout  output  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (async, n_reset=0):
  - FIFO empty; in_ready=1.
  - adder_a, adder_b, out_sum = 16'h0000.
  - out_valid, busy, timeout = 0.
  - State IDLE; watchdog counter = 0.
- FIFO:
  - Push when in_valid & in_ready.
  - No pass-through: a push and a pop may occur in the same cycle, but a push into a full FIFO is refused even if a pop occurs that cycle.
  - Read/write pointers wrap modulo DEPTH, with an extra bit to distinguish full from empty.
- Only one operation is in flight at a time. The op registers (adder_a/adder_b) change only on a pop.
- States:
  - IDLE: if FIFO non-empty and out_valid=0 -> pop head into adder_a/adder_b, clear watchdog, go LOAD. Otherwise stay.
  - LOAD: operands are now stable. On adder_ready=1 -> go BUSY and clear watchdog; the adder samples a/b on its following cycles. Any adder run already in progress with stale operands completes during LOAD; its result is ignored.
  - BUSY: on adder_ready=1 -> out_sum <= adder_sum, out_valid <= 1, go IDLE.
  - Watchdog in LOAD/BUSY: counter increments each cycle with adder_ready=0. When it reaches TIMEOUT_CYCLES-1:
    - timeout pulses high for 1 cycle;
    - go IDLE; the popped pair is discarded; out_valid is unchanged.
- Result handshake:
  - out_valid clears on out_ready & out_valid.
  - If capture and drain occur in the same cycle: capture has priority and out_valid stays 1 with the new data. This cannot occur with a single outstanding operation, but it is specified for robustness.
- Latency:
  - Minimum 2 adder ready pulses after a pop.
  - First result no earlier than 3 cycles after the push into an empty FIFO; otherwise it is governed by the adder's run length.
- Ordering: results appear strictly in push order. Timed-out pairs produce no result.
- adder_ready held high continuously (adder stuck idle): LOAD->BUSY->IDLE in consecutive cycles. This is treated as legal; the captured sum is whatever adder_sum presents.
- Reset mid-operation: immediate return to reset values. FIFO contents and the in-flight pair are lost.

Optional Feature:
- Macro: BF16_SEQ_STATS_EN.
- Defined:
  - Adds outputs ops_done[15:0] and timeouts[15:0].
  - Both are saturating counters, reset to 0.
  - ops_done increments on each result capture; timeouts increments on each timeout pulse.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Adder model computing real bfloat16 sums. Push in_a=16'h3F80, in_b=16'h4000 (1.0+2.0) -> out_valid=1 with out_sum=16'h4040; busy returns to 0.
- out_ready held 0; offer 6 pairs back-to-back -> exactly 5 accepted (1 held in op registers, 4 in FIFO) and in_ready=0. Then raise out_ready -> 5 results in push order, after which in_ready=1.
- Adder model holds adder_ready=0 after the pop -> timeout pulses once, 64 cycles after entering LOAD; no out_valid. The next queued pair then completes normally.
- Assert n_reset low while in BUSY with 3 pairs queued -> same cycle: out_valid=0, busy=0, in_ready=1, adder_a=adder_b=0. After release, no results ever appear.
- Zero operand: push in_a=16'h0000, in_b=16'h4040 -> out_sum=16'h4040. Then push in_a=16'hC040, in_b=16'h4040 -> result captured, in order.
- With BF16_SEQ_STATS_EN: 3 successful operations plus 1 forced timeout -> ops_done=3, timeouts=1. Reset -> both 0.
